// File: rtl/d_sramlike_responder_if.sv
// Data-side sram-like bus between the CPU master and the responder.
// The master drives the request fields; the slave answers with the handshake, the completion pulse and read data.
interface d_sramlike_responder_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok
  );
endinterface

// File: rtl/d_sramlike_responder.sv
// Sram-like data-bus responder: one transaction in flight, fixed LATENCY from address handshake to data_ok,
// backed by a synchronous single-port 32-bit block RAM.
module d_sramlike_responder #(
  parameter int RAM_AW  = 10,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  d_sramlike_responder_if.slave bus,
  input  logic                  i_hold_addr,
  output logic                  o_err_misalign,
  output logic                  o_ram_en,
  output logic [3:0]            o_ram_wen,
  output logic [RAM_AW-1:0]     o_ram_addr,
  output logic [31:0]           o_ram_wdata,
  input  logic [31:0]           i_ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_wr;
  logic [1:0]        r_size;
  logic [1:0]        r_addr_lo;
  logic [RAM_AW-1:0] r_word;
  logic [31:0]       r_wdata;
  logic              r_misalign;
  logic [31:0]       r_last_rd;
  logic              r_data_ok;
  logic              r_err;
  logic              r_ram_en;
  logic [3:0]        r_ram_wen;
  logic [RAM_AW-1:0] r_ram_addr;
  logic [31:0]       r_ram_wdata;

  logic              w_accept;
  logic              w_in_misalign;
  logic [3:0]        w_in_wen;
  logic [3:0]        w_lat_wen;
  logic              w_drive_next;
  logic [3:0]        w_src_wen;
  logic [RAM_AW-1:0] w_src_addr;
  logic [31:0]       w_src_wdata;
  logic              w_unused_addr_hi;

  // Byte lanes touched by an access; the low address bits beyond the access size are ignored.
  function automatic logic [3:0] calcStrobe(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] strobe;
    case (size)
      2'd0:    strobe = 4'b0001 << lo;
      2'd1:    strobe = lo[1] ? 4'b1100 : 4'b0011;
      default: strobe = 4'b1111;
    endcase
    return strobe;
  endfunction

  assign w_accept      = resetn & (r_state == S_IDLE) & bus.data_req & ~i_hold_addr;
  assign w_in_misalign = ((bus.data_size == 2'd1) & bus.data_addr[0]) |
                         ((bus.data_size == 2'd2) & (bus.data_addr[1:0] != 2'b00));
  assign w_in_wen      = bus.data_wr ? calcStrobe(bus.data_size, bus.data_addr[1:0]) : 4'b0000;
  assign w_lat_wen     = r_wr ? calcStrobe(r_size, r_addr_lo) : 4'b0000;
  assign w_unused_addr_hi = ^bus.data_addr[31:RAM_AW+2];

  // RAM port is registered: it is loaded one edge ahead, straight from the bus when LATENCY is 2.
  assign w_drive_next = (w_accept && (CNT_LOAD == 4'd1)) || ((r_state == S_WAIT) && (r_cnt == 4'd2));
  assign w_src_wen    = (r_state == S_IDLE) ? w_in_wen : w_lat_wen;
  assign w_src_addr   = (r_state == S_IDLE) ? bus.data_addr[RAM_AW+1:2] : r_word;
  assign w_src_wdata  = (r_state == S_IDLE) ? bus.data_wdata : r_wdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_wr        <= 1'b0;
      r_size      <= 2'd0;
      r_addr_lo   <= 2'd0;
      r_word      <= '0;
      r_wdata     <= 32'd0;
      r_misalign  <= 1'b0;
      r_last_rd   <= 32'd0;
      r_data_ok   <= 1'b0;
      r_err       <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_wen   <= 4'b0000;
      r_ram_addr  <= '0;
      r_ram_wdata <= 32'd0;
    end else begin
      r_data_ok   <= 1'b0;
      r_err       <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_wen   <= 4'b0000;
      r_ram_addr  <= '0;
      r_ram_wdata <= 32'd0;
      if (w_drive_next) begin
        r_ram_en    <= 1'b1;
        r_ram_wen   <= w_src_wen;
        r_ram_addr  <= w_src_addr;
        r_ram_wdata <= w_src_wdata;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_wr       <= bus.data_wr;
            r_size     <= bus.data_size;
            r_addr_lo  <= bus.data_addr[1:0];
            r_word     <= bus.data_addr[RAM_AW+1:2];
            r_wdata    <= bus.data_wdata;
            r_misalign <= w_in_misalign;
            r_cnt      <= CNT_LOAD;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_data_ok <= 1'b1;
            r_err     <= r_misalign;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (!r_wr) begin
            r_last_rd <= i_ram_rdata;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.data_addr_ok = w_accept;
  assign bus.data_data_ok = r_data_ok;
  // Read data is passed through in the response cycle; otherwise the last read value is held.
  assign bus.data_rdata   = ((r_state == S_RESP) && !r_wr) ? i_ram_rdata : r_last_rd;
  assign o_err_misalign   = r_err;
  assign o_ram_en         = r_ram_en;
  assign o_ram_wen        = r_ram_wen;
  assign o_ram_addr       = r_ram_addr;
  assign o_ram_wdata      = r_ram_wdata;

endmodule

// File: tb/tb_d_sramlike_responder.sv
// Directed bench for d_sramlike_responder: one LATENCY=2 instance for functional vectors,
// one LATENCY=4 instance for back-to-back throughput and mid-transaction reset.
module tb_d_sramlike_responder;

  logic clk;
  logic resetn;

  d_sramlike_responder_if b2 ();
  d_sramlike_responder_if b4 ();

  logic        hold2, hold4;
  logic        err2, err4;
  logic        ram2En, ram4En;
  logic [3:0]  ram2Wen, ram4Wen;
  logic [9:0]  ram2Addr, ram4Addr;
  logic [31:0] ram2Wdata, ram4Wdata;
  logic [31:0] ram2Rdata, ram4Rdata;
  logic [31:0] mem2 [0:1023];
  logic [31:0] mem4 [0:1023];

  int checkCount = 0;
  int errorCount = 0;
  int okCount;
  logic [31:0] lastRead2;

  d_sramlike_responder #(.RAM_AW(10), .LATENCY(2)) dut2 (
    .clk(clk), .resetn(resetn), .bus(b2), .i_hold_addr(hold2), .o_err_misalign(err2),
    .o_ram_en(ram2En), .o_ram_wen(ram2Wen), .o_ram_addr(ram2Addr), .o_ram_wdata(ram2Wdata),
    .i_ram_rdata(ram2Rdata)
  );

  d_sramlike_responder #(.RAM_AW(10), .LATENCY(4)) dut4 (
    .clk(clk), .resetn(resetn), .bus(b4), .i_hold_addr(hold4), .o_err_misalign(err4),
    .o_ram_en(ram4En), .o_ram_wen(ram4Wen), .o_ram_addr(ram4Addr), .o_ram_wdata(ram4Wdata),
    .i_ram_rdata(ram4Rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM models with byte write enables.
  always @(posedge clk) begin
    if (ram2En) begin
      for (int b = 0; b < 4; b++)
        if (ram2Wen[b]) mem2[ram2Addr][8*b +: 8] <= ram2Wdata[8*b +: 8];
      ram2Rdata <= mem2[ram2Addr];
    end
    if (ram4En) begin
      for (int b = 0; b < 4; b++)
        if (ram4Wen[b]) mem4[ram4Addr][8*b +: 8] <= ram4Wdata[8*b +: 8];
      ram4Rdata <= mem4[ram4Addr];
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic wr, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    b2.data_req   = 1'b1;
    b2.data_wr    = wr;
    b2.data_size  = size;
    b2.data_addr  = addr;
    b2.data_wdata = wdata;
    #1;
    checkOutput({tag, " addr_ok"}, b2.data_addr_ok, 1);
  endtask

  task automatic readCycle(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic [9:0] expWord, input logic [31:0] expData, input logic expErr);
    applyStimulus(tag, 1'b0, size, addr, 32'h0);
    @(negedge clk);
    b2.data_req = 1'b0;
    checkOutput({tag, " ram_en"}, ram2En, 1);
    checkOutput({tag, " ram_addr"}, ram2Addr, expWord);
    checkOutput({tag, " ram_wen"}, ram2Wen, 0);
    checkOutput({tag, " early data_ok"}, b2.data_data_ok, 0);
    @(negedge clk);
    checkOutput({tag, " data_ok"}, b2.data_data_ok, 1);
    checkOutput({tag, " rdata"}, b2.data_rdata, expData);
    checkOutput({tag, " err"}, err2, expErr);
    lastRead2 = expData;
    @(negedge clk);
    checkOutput({tag, " data_ok drop"}, b2.data_data_ok, 0);
    checkOutput({tag, " err drop"}, err2, 0);
  endtask

  task automatic writeCycle(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] data, input logic [3:0] expWen, input logic expErr);
    applyStimulus(tag, 1'b1, size, addr, data);
    @(negedge clk);
    b2.data_req = 1'b0;
    checkOutput({tag, " ram_en"}, ram2En, 1);
    checkOutput({tag, " ram_wen"}, ram2Wen, expWen);
    checkOutput({tag, " ram_wdata"}, ram2Wdata, data);
    @(negedge clk);
    checkOutput({tag, " data_ok"}, b2.data_data_ok, 1);
    checkOutput({tag, " err"}, err2, expErr);
    checkOutput({tag, " rdata held"}, b2.data_rdata, lastRead2);
    @(negedge clk);
    checkOutput({tag, " data_ok drop"}, b2.data_data_ok, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem2[i] = 32'h0;
      mem4[i] = 32'h0;
    end
    mem2[4]  = 32'hDEADBEEF;
    mem2[8]  = 32'hCAFEF00D;
    mem4[8]  = 32'h12345678;
    mem4[16] = 32'h55AA55AA;
    resetn = 1'b0;
    hold2 = 1'b0;
    hold4 = 1'b0;
    lastRead2 = 32'h0;
    b2.data_req = 1'b0; b2.data_wr = 1'b0; b2.data_size = 2'd0; b2.data_addr = 32'h0; b2.data_wdata = 32'h0;
    b4.data_req = 1'b0; b4.data_wr = 1'b0; b4.data_size = 2'd0; b4.data_addr = 32'h0; b4.data_wdata = 32'h0;

    // Outputs stay quiet in reset even with a request pending.
    @(negedge clk);
    b2.data_req = 1'b1;
    #1;
    checkOutput("reset addr_ok", b2.data_addr_ok, 0);
    checkOutput("reset data_ok", b2.data_data_ok, 0);
    checkOutput("reset ram_en", ram2En, 0);
    checkOutput("reset ram_wen", ram2Wen, 0);
    checkOutput("reset rdata", b2.data_rdata, 0);
    checkOutput("reset err", err2, 0);
    @(negedge clk);
    b2.data_req = 1'b0;
    resetn = 1'b1;

    readCycle("rd 0x10", 32'h10, 2'd2, 10'd4, 32'hDEADBEEF, 1'b0);
    writeCycle("wrb 0x13", 32'h13, 2'd0, 32'hAB000000, 4'b1000, 1'b0);
    readCycle("rd 0x10 after wr", 32'h10, 2'd2, 10'd4, 32'hABADBEEF, 1'b0);

    writeCycle("wrh 0x32", 32'h32, 2'd1, 32'h12340000, 4'b1100, 1'b0);
    writeCycle("wrb 0x31", 32'h31, 2'd0, 32'h00005600, 4'b0010, 1'b0);
    writeCycle("wrb 0x30", 32'h30, 2'd0, 32'h00000078, 4'b0001, 1'b0);
    readCycle("rd 0x30", 32'h30, 2'd2, 10'd12, 32'h12345678, 1'b0);
    writeCycle("wrw mis 0x41", 32'h41, 2'd2, 32'hA5A5A5A5, 4'b1111, 1'b1);
    writeCycle("wrh mis 0x43", 32'h43, 2'd1, 32'h5A5A0000, 4'b1100, 1'b1);
    readCycle("rd wrap 0x10000040", 32'h1000_0040, 2'd2, 10'd16, 32'h5A5AA5A5, 1'b0);
    writeCycle("wr size3 0x50", 32'h50, 2'd3, 32'h0F0F0F0F, 4'b1111, 1'b0);
    readCycle("rdh mis 0x21", 32'h21, 2'd1, 10'd8, 32'hCAFEF00D, 1'b1);

    // Backpressure: no accept while held, accept the cycle hold drops, hold during WAIT is harmless.
    @(negedge clk);
    hold2 = 1'b1;
    b2.data_req = 1'b1; b2.data_wr = 1'b0; b2.data_size = 2'd2; b2.data_addr = 32'h10;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput($sformatf("hold addr_ok c%0d", i), b2.data_addr_ok, 0);
      @(negedge clk);
    end
    hold2 = 1'b0;
    #1;
    checkOutput("hold release addr_ok", b2.data_addr_ok, 1);
    @(negedge clk);
    hold2 = 1'b1;
    checkOutput("hold wait data_ok", b2.data_data_ok, 0);
    @(negedge clk);
    hold2 = 1'b0;
    #1;
    checkOutput("hold resp data_ok", b2.data_data_ok, 1);
    checkOutput("hold resp rdata", b2.data_rdata, 32'hABADBEEF);
    checkOutput("resp no accept", b2.data_addr_ok, 0);
    @(negedge clk);
    checkOutput("idle reaccept addr_ok", b2.data_addr_ok, 1);
    b2.data_req = 1'b0;
    lastRead2 = 32'hABADBEEF;

    // LATENCY=4 with request held high: one accept every 5 cycles, one response each.
    b4.data_wr = 1'b0; b4.data_size = 2'd2; b4.data_addr = 32'h20;
    okCount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) b4.data_req = 1'b1;
      #1;
      checkOutput($sformatf("b2b addr_ok c%0d", i), b4.data_addr_ok, (i % 5 == 0) ? 1 : 0);
      checkOutput($sformatf("b2b ram_en c%0d", i), ram4En, (i % 5 == 3) ? 1 : 0);
      checkOutput($sformatf("b2b data_ok c%0d", i), b4.data_data_ok, (i % 5 == 4) ? 1 : 0);
      if (b4.data_data_ok) okCount++;
      if (i % 5 == 4) checkOutput($sformatf("b2b rdata c%0d", i), b4.data_rdata, 32'h12345678);
    end
    @(negedge clk);
    b4.data_req = 1'b0;
    checkOutput("b2b response count", okCount, 4);

    // Reset during WAIT of a write: nothing reaches the RAM, no response.
    @(negedge clk);
    b4.data_req = 1'b1; b4.data_wr = 1'b1; b4.data_size = 2'd2; b4.data_addr = 32'h40; b4.data_wdata = 32'hFFFFFFFF;
    #1;
    checkOutput("rst-mid addr_ok", b4.data_addr_ok, 1);
    @(negedge clk);
    b4.data_req = 1'b0;
    checkOutput("rst-mid wait ram_en", ram4En, 0);
    resetn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("rst-mid ram_en c%0d", i), ram4En, 0);
      checkOutput($sformatf("rst-mid data_ok c%0d", i), b4.data_data_ok, 0);
      @(negedge clk);
    end
    resetn = 1'b1;
    @(negedge clk);
    b4.data_req = 1'b1; b4.data_wr = 1'b0; b4.data_size = 2'd2; b4.data_addr = 32'h40;
    #1;
    checkOutput("post-rst addr_ok", b4.data_addr_ok, 1);
    @(negedge clk);
    b4.data_req = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("post-rst data_ok", b4.data_data_ok, 1);
    checkOutput("post-rst rdata", b4.data_rdata, 32'h55AA55AA);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
